// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer for an external up/down/load counter: loads lo, counts up to hi,
// back down to lo, repeated for a captured number of sweeps, then pulses done.
module counter_sweep_ctrl #(
    parameter int BITS     = 4,
    parameter int CYC_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [BITS-1:0]     lo,
    input  logic [BITS-1:0]     hi,
    input  logic [CYC_BITS-1:0] cycles,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [CYC_BITS-1:0] cur_cycle,
    output logic                cnt_up,
    output logic                cnt_en,
    output logic                cnt_load,
    output logic [BITS-1:0]     cnt_d,
    input  logic [BITS-1:0]     cnt_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DOWN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BITS-1:0]     r_lo;
    logic [BITS-1:0]     r_hi;
    logic [CYC_BITS-1:0] r_cyc;
    logic [CYC_BITS-1:0] r_cur_cycle;
    logic                r_err;

    logic                w_cfg_bad;
    logic                w_at_hi;
    logic                w_at_lo;
    logic [CYC_BITS-1:0] w_cyc_inc;
    logic                w_last_sweep;

    // Bad config is judged on the live inputs, since that is what gets captured.
    assign w_cfg_bad    = (lo >= hi) || (cycles == '0);
    assign w_at_hi      = (cnt_q == r_hi);
    assign w_at_lo      = (cnt_q == r_lo);
    assign w_cyc_inc    = r_cur_cycle + CYC_BITS'(1);
    assign w_last_sweep = (w_cyc_inc == r_cyc);
    assign cur_cycle    = r_cur_cycle;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_cfg_bad ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: w_state_nxt = abort ? S_DONE : S_UP;
            S_UP: begin
                if (abort) begin
                    w_state_nxt = S_DONE;
                end else if (w_at_hi) begin
                    w_state_nxt = S_DOWN;
                end
            end
            S_DOWN: begin
                if (abort) begin
                    w_state_nxt = S_DONE;
                end else if (w_at_lo) begin
                    w_state_nxt = w_last_sweep ? S_DONE : S_UP;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        cnt_up   = 1'b0;
        cnt_en   = 1'b0;
        cnt_load = 1'b0;
        cnt_d    = '0;
        case (r_state)
            S_LOAD: begin
                busy     = 1'b1;
                cnt_load = !abort;
                cnt_d    = r_lo;
            end
            S_UP: begin
                busy   = 1'b1;
                cnt_up = 1'b1;
                cnt_en = !w_at_hi && !abort;
            end
            S_DOWN: begin
                busy   = 1'b1;
                cnt_en = !w_at_lo && !abort;
            end
            S_DONE: begin
                done = 1'b1;
                err  = r_err;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lo        <= '0;
            r_hi        <= '0;
            r_cyc       <= '0;
            r_cur_cycle <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && start) begin
                r_lo        <= lo;
                r_hi        <= hi;
                r_cyc       <= cycles;
                r_cur_cycle <= '0;
                r_err       <= w_cfg_bad;
            end
            // Sweep completes when the down-count reaches lo; saturate at the target.
            if (r_state == S_DOWN && !abort && w_at_lo && r_cur_cycle != r_cyc) begin
                r_cur_cycle <= w_cyc_inc;
            end
        end
    end

endmodule
